ws2811_transmitter: RTL and testbench
=====================================

WS2811_TRANSMITTER -- requirements
Module: ws2811_transmitter

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 50, meaning pixels per frame (range 1..256).
REQ-002 SHALL have parameter PIXEL_SETTLE_CYC, default 32, meaning cycles between a ledindex change and valid red/green/blue from the pixel controller.
REQ-003 SHALL have parameter TBIT_CYC, default 125, meaning total bit period in clk cycles (2.5 us at 50 MHz).
REQ-004 SHALL have parameter T0H_CYC, default 25, meaning high time of a 0 bit.
REQ-005 SHALL have parameter T1H_CYC, default 60, meaning high time of a 1 bit.
REQ-006 SHALL have parameter TRESET_CYC, default 2500, meaning low latch gap after a frame (50 us).
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-009 SHALL have port enable, input, 1 bit, request to start or continue frames.
REQ-010 SHALL have ports red, green and blue, input, 8 bits each, the pixel colour for the current ledindex.
REQ-011 SHALL have port ledindex, output, 8 bits, the pixel currently being fetched.
REQ-012 SHALL have port data_out, output, 1 bit, the WS2811 serial line.
REQ-013 SHALL have port busy, output, 1 bit, high from frame start until frame_done.
REQ-014 SHALL have port frame_done, output, 1 bit, a one-cycle pulse at the end of the latch gap.

Function
REQ-015 SHALL implement the states IDLE, SETTLE, SEND and LATCH.
REQ-016 In IDLE, enable=1 SHALL set ledindex=0 and busy=1, and SHALL move to SETTLE.
REQ-017 SETTLE SHALL wait PIXEL_SETTLE_CYC cycles, then load the 24-bit shift register from red/green/blue and enter SEND, with data_out rising on the same edge.
REQ-018 Consequently, the first data_out rise SHALL occur PIXEL_SETTLE_CYC+1 edges after enable is sampled high in IDLE.
REQ-019 Each bit SHALL drive data_out high for T1H_CYC (bit=1) or T0H_CYC (bit=0) cycles, then low for the remainder of TBIT_CYC; bits go MSB first.
REQ-020 On each load, ledindex SHALL increment on the same edge, so the next pixel settles during the current pixel's transmission.
REQ-021 After bit 23 of a non-final pixel, the next pixel SHALL load with no gap, so the bit period stays exactly TBIT_CYC.
REQ-022 On the final pixel, ledindex SHALL hold at NUM_LEDS-1 with no increment or wrap.
REQ-023 After the final bit, the block SHALL enter LATCH with data_out=0 for TRESET_CYC cycles, then pulse frame_done for 1 cycle, clear busy and return to IDLE.
REQ-024 If enable=1 on the frame_done cycle, a new frame SHALL start on the next edge.
REQ-025 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame completes in full, including LATCH.
REQ-026 The red/green/blue inputs SHALL be sampled only on load edges; changes at any other time SHALL be ignored.
REQ-027 Total frame length SHALL be PIXEL_SETTLE_CYC+1 + NUM_LEDS*24*TBIT_CYC + TRESET_CYC cycles.
REQ-028 Parameter legality SHALL be T0H_CYC < T1H_CYC < TBIT_CYC and PIXEL_SETTLE_CYC < 24*TBIT_CYC; behaviour outside these limits is undefined.

Reset
REQ-029 While rst_n=0, the outputs SHALL be data_out=0, busy=0, frame_done=0 and ledindex=0, and the state SHALL be IDLE with all counters and the shift register at 0.
REQ-030 Assertion of rst_n mid-bit SHALL force data_out low immediately, without waiting for a clock edge.
REQ-031 After rst_n is released, no transmission SHALL start until enable is sampled high.

Configuration
REQ-032 The macro WS2811_GRB_ORDER_EN SHALL select the shift-register load order.
- Defined: the load order SHALL be {green, red, blue}.
- Undefined: the load order SHALL be {red, green, blue}.

Verification
REQ-033 NUM_LEDS=1, red=0x80, green=0x01, blue=0xFF, macro undefined -> bit high times: 60, 25x7, 25x7, 60, 60x8 cycles; bit period 125; then 2500 cycles low and a frame_done pulse.
REQ-034 Same stimulus with WS2811_GRB_ORDER_EN defined -> first byte is 0x01: high times 25x7, then 60.
REQ-035 NUM_LEDS=3 with enable held high -> ledindex steps 0,1,2; no gap between pixels; frame length 33+3*3000+2500=11533 cycles; the next frame's ledindex returns to 0.
REQ-036 enable pulsed for 1 cycle, then dropped -> a full frame is sent, busy stays high throughout, and the block then idles.
REQ-037 rst_n asserted during a 1-bit high phase -> data_out=0 asynchronously; after release with enable=1, a new frame starts from ledindex=0 with the settle delay.
REQ-038 red/green/blue changed mid-pixel -> the transmitted bits match the values present on the load edge only.

Source files
------------

// File: rtl/ws2811_transmitter.sv
// -----------------------------------------------------------------------------
// ws2811_transmitter
//
// Serialises a frame of NUM_LEDS 24-bit pixels onto a single WS2811 data line.
// For every pixel the block presents an index on ledindex, waits for the pixel
// controller to settle, samples red/green/blue into a shift register and sends
// the 24 bits MSB first. Each bit is a fixed TBIT_CYC period: high for T1H_CYC
// (bit=1) or T0H_CYC (bit=0), then low. After the last pixel the line is held
// low for TRESET_CYC cycles so the LEDs latch, and frame_done pulses once.
//
// Configuration macro:
//   WS2811_GRB_ORDER_EN  defined   -> pixel word is {green, red, blue}
//                        undefined -> pixel word is {red, green, blue}
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   start a frame (sampled in IDLE only)
//   red        in   [7:0] colour of the pixel at ledindex
//   green      in   [7:0] colour of the pixel at ledindex
//   blue       in   [7:0] colour of the pixel at ledindex
//   ledindex   out  [7:0] pixel currently being fetched
//   data_out   out  WS2811 serial line
//   busy       out  high from frame start until frame_done
//   frame_done out  one-cycle pulse at the end of the latch gap
// -----------------------------------------------------------------------------
module ws2811_transmitter #(
    parameter int NUM_LEDS         = 50,
    parameter int PIXEL_SETTLE_CYC = 32,
    parameter int TBIT_CYC         = 125,
    parameter int T0H_CYC          = 25,
    parameter int T1H_CYC          = 60,
    parameter int TRESET_CYC       = 2500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [7:0] ledindex,
    output logic       data_out,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SEND   = 2'd2,
        LATCH  = 2'd3
    } state_t;

    // Counter terminal values; every counter restarts at 0 when its state begins.
    localparam logic [31:0] SETTLE_LAST = 32'(PIXEL_SETTLE_CYC);
    localparam logic [31:0] BIT_LAST    = 32'(TBIT_CYC - 1);
    localparam logic [31:0] LATCH_LAST  = 32'(TRESET_CYC - 1);
    localparam logic [31:0] T0H         = 32'(T0H_CYC);
    localparam logic [31:0] T1H         = 32'(T1H_CYC);
    localparam logic [7:0]  LAST_IDX    = 8'(NUM_LEDS - 1);
    localparam logic [4:0]  LAST_BIT    = 5'd23;

    state_t      state_r, state_s;
    logic [31:0] cnt_r, cnt_s;
    logic [4:0]  bit_idx_r, bit_idx_s;
    logic [23:0] shift_r, shift_s;
    logic [7:0]  ledindex_r, ledindex_s;
    logic        last_pix_r, last_pix_s;
    logic        busy_r, busy_s;
    logic        data_out_r, data_out_s;
    logic        frame_done_r, frame_done_s;
    logic [23:0] pixel_word_s;

    // High time of a bit with the given value.
    function automatic logic [31:0] high_cycles(input logic bit_val);
        logic [31:0] cyc;
        if (bit_val) begin
            cyc = T1H;
        end else begin
            cyc = T0H;
        end
        return cyc;
    endfunction

`ifdef WS2811_GRB_ORDER_EN
    assign pixel_word_s = {green, red, blue};
`else
    assign pixel_word_s = {red, green, blue};
`endif

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        bit_idx_s    = bit_idx_r;
        shift_s      = shift_r;
        ledindex_s   = ledindex_r;
        last_pix_s   = last_pix_r;
        busy_s       = busy_r;
        data_out_s   = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s    = SETTLE;
                    cnt_s      = 32'd0;
                    ledindex_s = 8'd0;
                    busy_s     = 1'b1;
                end else begin
                    busy_s     = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    // First pixel load: the line rises on this same edge.
                    state_s    = SEND;
                    cnt_s      = 32'd0;
                    bit_idx_s  = 5'd0;
                    shift_s    = pixel_word_s;
                    data_out_s = (32'd0 < high_cycles(pixel_word_s[23]));
                    last_pix_s = (ledindex_r == LAST_IDX);
                    if (ledindex_r == LAST_IDX) begin
                        ledindex_s = ledindex_r;
                    end else begin
                        ledindex_s = ledindex_r + 8'd1;
                    end
                end else begin
                    cnt_s = cnt_r + 32'd1;
                end
            end
            SEND: begin
                if (cnt_r != BIT_LAST) begin
                    cnt_s      = cnt_r + 32'd1;
                    data_out_s = ((cnt_r + 32'd1) < high_cycles(shift_r[23]));
                end else if (bit_idx_r != LAST_BIT) begin
                    cnt_s      = 32'd0;
                    bit_idx_s  = bit_idx_r + 5'd1;
                    shift_s    = {shift_r[22:0], 1'b0};
                    data_out_s = (32'd0 < high_cycles(shift_r[22]));
                end else if (!last_pix_r) begin
                    // Back-to-back reload keeps the bit grid unbroken; ledindex
                    // already points at this pixel and has settled meanwhile.
                    cnt_s      = 32'd0;
                    bit_idx_s  = 5'd0;
                    shift_s    = pixel_word_s;
                    data_out_s = (32'd0 < high_cycles(pixel_word_s[23]));
                    last_pix_s = (ledindex_r == LAST_IDX);
                    if (ledindex_r == LAST_IDX) begin
                        ledindex_s = ledindex_r;
                    end else begin
                        ledindex_s = ledindex_r + 8'd1;
                    end
                end else begin
                    state_s = LATCH;
                    cnt_s   = 32'd0;
                end
            end
            LATCH: begin
                if (cnt_r == LATCH_LAST) begin
                    state_s      = IDLE;
                    cnt_s        = 32'd0;
                    busy_s       = 1'b0;
                    frame_done_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 32'd1;
                end
            end
            default: begin
                state_s    = IDLE;
                cnt_s      = 32'd0;
                bit_idx_s  = 5'd0;
                shift_s    = 24'd0;
                ledindex_s = 8'd0;
                last_pix_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears data_out without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 32'd0;
            bit_idx_r    <= 5'd0;
            shift_r      <= 24'd0;
            ledindex_r   <= 8'd0;
            last_pix_r   <= 1'b0;
            busy_r       <= 1'b0;
            data_out_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            bit_idx_r    <= bit_idx_s;
            shift_r      <= shift_s;
            ledindex_r   <= ledindex_s;
            last_pix_r   <= last_pix_s;
            busy_r       <= busy_s;
            data_out_r   <= data_out_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign ledindex   = ledindex_r;
    assign data_out   = data_out_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_ws2811_transmitter.sv
// -----------------------------------------------------------------------------
// tb_ws2811_transmitter
//
// Directed bench for ws2811_transmitter with NUM_LEDS=3 and default timing.
// A small colour table plays the pixel controller, indexed by ledindex.
// Frames: A (enable held, colours changed mid-frame), B (auto restart, then
// reset mid high phase), B2 (after reset, enable dropped mid-frame),
// C (one-cycle enable pulse). Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ws2811_transmitter;

    localparam int NLED   = 3;
    localparam int SETTLE = 32;
    localparam int TBIT   = 125;
    localparam int T0H    = 25;
    localparam int T1H    = 60;
    localparam int TRST   = 2500;
    localparam int FRAME  = SETTLE + 1 + NLED * 24 * TBIT + TRST;  // 11533

`ifdef WS2811_GRB_ORDER_EN
    localparam logic [23:0] W0_HAND = 24'h0180FF;
`else
    localparam logic [23:0] W0_HAND = 24'h8001FF;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] red, green, blue;
    logic [7:0] ledindex;
    logic       data_out, busy, frame_done;

    logic [7:0] tbl_r [4];
    logic [7:0] tbl_g [4];
    logic [7:0] tbl_b [4];

    int n_asserts  = 0;
    int n_fails    = 0;
    int cyc        = 0;
    int busy_drops = 0;
    bit track_busy = 1'b0;

    assign red   = tbl_r[ledindex[1:0]];
    assign green = tbl_g[ledindex[1:0]];
    assign blue  = tbl_b[ledindex[1:0]];

    ws2811_transmitter #(
        .NUM_LEDS        (NLED),
        .PIXEL_SETTLE_CYC(SETTLE),
        .TBIT_CYC        (TBIT),
        .T0H_CYC         (T0H),
        .T1H_CYC         (T1H),
        .TRESET_CYC      (TRST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .ledindex  (ledindex),
        .data_out  (data_out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] mk_word(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
`ifdef WS2811_GRB_ORDER_EN
        return {g, r, b};
`else
        return {r, g, b};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (track_busy && busy !== 1'b1 && frame_done !== 1'b1) busy_drops++;
    endtask

    // Entry: data_out sampled high (first cycle of a bit).
    task automatic measure_bit(output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (data_out === 1'b1 && hi < 1000) begin
            step();
            hi++;
        end
        while (data_out !== 1'b1 && lo < TBIT) begin
            step();
            lo++;
        end
    endtask

    // Entry: the falling edge right after the edge that started the frame.
    task automatic run_frame(input string name, input logic [23:0] w0,
                             input logic [23:0] w1, input logic [23:0] w2,
                             input bit do_change, input bit drop_en);
        int t0;
        int hi;
        int lo;
        int waited;
        int lat_hi;
        logic [23:0] w;
        t0 = cyc;
        chk({name, " start busy"}, 32'(busy), 32'd1);
        chk({name, " start ledindex"}, 32'(ledindex), 32'd0);
        chk({name, " start data_out"}, 32'(data_out), 32'd0);
        if (drop_en) enable = 1'b0;
        busy_drops = 0;
        track_busy = 1'b1;
        waited = 0;
        while (data_out !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        chk({name, " first rise latency"}, cyc - t0, SETTLE + 1);
        for (int p = 0; p < NLED; p++) begin
            w = (p == 0) ? w0 : ((p == 1) ? w1 : w2);
            chk({name, " ledindex at load"}, 32'(ledindex), (p + 1 < NLED) ? p + 1 : NLED - 1);
            for (int i = 0; i < 24; i++) begin
                measure_bit(hi, lo);
                chk({name, " bit high time"}, hi, w[23 - i] ? T1H : T0H);
                if (!(p == NLED - 1 && i == 23)) chk({name, " bit period"}, hi + lo, TBIT);
                if (do_change && i == 5 && p == 0) begin
                    tbl_r[1] = 8'h12;
                    tbl_g[1] = 8'h34;
                    tbl_b[1] = 8'h56;
                end
                if (do_change && i == 5 && p == NLED - 1) begin
                    tbl_r[2] = 8'hEE;
                    tbl_g[2] = 8'hEE;
                    tbl_b[2] = 8'hEE;
                end
            end
        end
        lat_hi = 0;
        waited = 0;
        while (frame_done !== 1'b1 && waited < TRST + 200) begin
            if (data_out !== 1'b0) lat_hi++;
            step();
            waited++;
        end
        track_busy = 1'b0;
        chk({name, " frame length"}, cyc - t0, FRAME);
        chk({name, " frame_done"}, 32'(frame_done), 32'd1);
        chk({name, " busy at frame_done"}, 32'(busy), 32'd0);
        chk({name, " ledindex held at last"}, 32'(ledindex), NLED - 1);
        chk({name, " latch line low"}, lat_hi, 0);
        chk({name, " busy held during frame"}, busy_drops, 0);
    endtask

    initial begin
        int t0;
        int waited;
        int idle_bad;
        rst_n  = 1'b0;
        enable = 1'b0;
        tbl_r[0] = 8'h80; tbl_g[0] = 8'h01; tbl_b[0] = 8'hFF;
        tbl_r[1] = 8'hA5; tbl_g[1] = 8'h5A; tbl_b[1] = 8'hC3;
        tbl_r[2] = 8'h3C; tbl_g[2] = 8'hE7; tbl_b[2] = 8'h18;
        tbl_r[3] = 8'h00; tbl_g[3] = 8'h00; tbl_b[3] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset data_out", 32'(data_out), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        chk("reset ledindex", 32'(ledindex), 32'd0);

        // No activity without enable
        rst_n = 1'b1;
        idle_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || data_out !== 1'b0) idle_bad++;
        end
        chk("idle after reset", idle_bad, 0);

        // Frame A: enable held, pixel 1 changed before its load, pixel 2 after
        enable = 1'b1;
        @(negedge clk);
        run_frame("A", W0_HAND, mk_word(8'h12, 8'h34, 8'h56),
                  mk_word(8'h3C, 8'hE7, 8'h18), 1'b1, 1'b0);
        tbl_r[0] = 8'hC3; tbl_g[0] = 8'h96; tbl_b[0] = 8'h3C;
        step();
        chk("A frame_done pulse width", 32'(frame_done), 32'd0);
        chk("B auto restart busy", 32'(busy), 32'd1);
        chk("B auto restart ledindex", 32'(ledindex), 32'd0);

        // Frame B: reset during the high phase of a 1 bit
        t0 = cyc;
        waited = 0;
        while (data_out !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("B first rise latency", cyc - t0, SETTLE + 1);
        repeat (40) @(negedge clk);
        chk("B mid 1-bit high", 32'(data_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset data_out", 32'(data_out), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset ledindex", 32'(ledindex), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame B2: after reset, enable dropped mid-frame
        run_frame("B2", mk_word(8'hC3, 8'h96, 8'h3C), mk_word(8'h12, 8'h34, 8'h56),
                  mk_word(8'hEE, 8'hEE, 8'hEE), 1'b0, 1'b1);
        step();
        chk("B2 frame_done pulse width", 32'(frame_done), 32'd0);
        chk("B2 no restart", 32'(busy), 32'd0);
        idle_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || data_out !== 1'b0) idle_bad++;
        end
        chk("idle after B2", idle_bad, 0);

        // Frame C: enable pulsed for exactly one cycle
        tbl_r[0] = 8'h00; tbl_g[0] = 8'hFF; tbl_b[0] = 8'h0F;
        tbl_r[1] = 8'hFF; tbl_g[1] = 8'h00; tbl_b[1] = 8'hF0;
        tbl_r[2] = 8'h55; tbl_g[2] = 8'hAA; tbl_b[2] = 8'h11;
        enable = 1'b1;
        @(negedge clk);
        run_frame("C", mk_word(8'h00, 8'hFF, 8'h0F), mk_word(8'hFF, 8'h00, 8'hF0),
                  mk_word(8'h55, 8'hAA, 8'h11), 1'b0, 1'b1);
        step();
        chk("C frame_done pulse width", 32'(frame_done), 32'd0);
        idle_bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0 || data_out !== 1'b0 || frame_done !== 1'b0) idle_bad++;
        end
        chk("idle after C", idle_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
